// File: rtl/lock_water_level_if.sv
// lock_water_level_if
//   Operator/gate-controller side signals of the lock chamber level controller.
//   master : operator panel / gate controller side (drives requests and gate_state)
//   slave  : level controller side (drives water_status, level, busy)
//   Signals:
//     fill_req      request to raise chamber to upper height (level-sensitive)
//     drain_req     request to lower chamber to lower height (level-sensitive)
//     gate_state    2'b00 both closed, 2'b01 upper open, 2'b10 lower open
//     water_status  2'b10 low/idle, 2'b11 high/idle, 2'b01 moving or held, 2'b00 idle mid-level
//     level         current chamber level
//     busy          high while filling or draining
interface lock_water_level_if #(
  parameter int unsigned LW = 4
);
  logic          fill_req;
  logic          drain_req;
  logic [1:0]    gate_state;
  logic [1:0]    water_status;
  logic [LW-1:0] level;
  logic          busy;

  modport master (
    output fill_req, drain_req, gate_state,
    input  water_status, level, busy
  );

  modport slave (
    input  fill_req, drain_req, gate_state,
    output water_status, level, busy
  );
endinterface

// File: rtl/lock_water_level.sv
// lock_water_level
//   Lock-chamber water level model and valve controller. Fill/drain requests
//   start a move that steps the level counter by one every STEP_DIV cycles
//   until the upper (LEVEL_MAX) or lower (0) height is reached. Valves are
//   frozen whenever any gate is open. Outputs decode registered state only.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; clears state, level and prescaler
//     bus    lock_water_level_if.slave (requests/gate_state in, status out)
module lock_water_level #(
  parameter int unsigned LEVEL_MAX = 15,
  parameter int unsigned LW        = 4,
  parameter int unsigned STEP_DIV  = 50,
  parameter int unsigned DW        = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  lock_water_level_if.slave        bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FILLING  = 2'd1;
  localparam logic [1:0] S_DRAINING = 2'd2;

  localparam logic [LW-1:0] L_MAX     = LW'(LEVEL_MAX);
  localparam logic [LW-1:0] L_MAX_M1  = LW'(LEVEL_MAX - 1);
  localparam logic [LW-1:0] L_ONE     = LW'(1);
  localparam logic [DW-1:0] P_LAST    = DW'(STEP_DIV - 1);

  logic [1:0]    r_state;
  logic [LW-1:0] r_level;
  logic [DW-1:0] r_presc;

  logic          w_gate_ok;
  logic          w_step;
  logic          w_fill_go;
  logic          w_drain_go;

  assign w_gate_ok  = (bus.gate_state == 2'b00);
  assign w_step     = (r_presc == P_LAST);
  // Simultaneous fill and drain cancel each other; move only toward a boundary not yet reached.
  assign w_fill_go  = bus.fill_req & ~bus.drain_req & w_gate_ok & (r_level < L_MAX);
  assign w_drain_go = bus.drain_req & ~bus.fill_req & w_gate_ok & (r_level != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_presc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fill_go) begin
            r_state <= S_FILLING;
            r_presc <= '0;
          end else if (w_drain_go) begin
            r_state <= S_DRAINING;
            r_presc <= '0;
          end
        end
        S_FILLING: begin
          // An open gate freezes prescaler and level; the move resumes where it stopped.
          if (w_gate_ok) begin
            if (w_step) begin
              r_presc <= '0;
              r_level <= r_level + L_ONE;
              if (r_level == L_MAX_M1) r_state <= S_IDLE;
            end else begin
              r_presc <= r_presc + DW'(1);
            end
          end
        end
        S_DRAINING: begin
          if (w_gate_ok) begin
            if (w_step) begin
              r_presc <= '0;
              r_level <= r_level - L_ONE;
              if (r_level == L_ONE) r_state <= S_IDLE;
            end else begin
              r_presc <= r_presc + DW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_presc <= '0;
        end
      endcase
    end
  end

  assign bus.level = r_level;
  assign bus.busy  = (r_state == S_FILLING) || (r_state == S_DRAINING);

  always_comb begin
    bus.water_status = 2'b00;
    if (r_state == S_FILLING || r_state == S_DRAINING) begin
      bus.water_status = 2'b01;
    end else if (r_level == '0) begin
      bus.water_status = 2'b10;
    end else if (r_level == L_MAX) begin
      bus.water_status = 2'b11;
    end
  end

endmodule

// File: tb/tb_lock_water_level.sv
module tb_lock_water_level;

  localparam int unsigned LEVEL_MAX = 3;
  localparam int unsigned LW        = 2;
  localparam int unsigned STEP_DIV  = 4;
  localparam int unsigned DW        = 2;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    int    at;
    string tag;
    int    lvl;
    int    st;
    int    bsy;
  } exp_t;

  exp_t sb[$];

  lock_water_level_if #(.LW(LW)) u_if ();

  lock_water_level #(
    .LEVEL_MAX (LEVEL_MAX),
    .LW        (LW),
    .STEP_DIV  (STEP_DIV),
    .DW        (DW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_at(input int at, input string tag, input int l, input int s, input int b);
    sb.push_back('{at, tag, l, s, b});
  endtask

  // Scoreboard consumer: compare every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        chk({e.tag, "_missed"}, cyc, e.at);
      end else begin
        chk({e.tag, "_level"},  int'(u_if.level),        e.lvl);
        chk({e.tag, "_status"}, int'(u_if.water_status), e.st);
        chk({e.tag, "_busy"},   int'(u_if.busy),         e.bsy);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
    #2;
  endtask

  // One-cycle request pulse, sampled at the next rising edge.
  task automatic pulse(input logic f, input logic d);
    u_if.fill_req  = f;
    u_if.drain_req = d;
    @(negedge clk);
    #2;
    u_if.fill_req  = 1'b0;
    u_if.drain_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    u_if.fill_req   = 1'b0;
    u_if.drain_req  = 1'b0;
    u_if.gate_state = 2'b00;

    // Async reset between edges
    #3 reset = 1'b1;
    #1;
    chk("rst_async_level",  int'(u_if.level), 0);
    chk("rst_async_status", int'(u_if.water_status), 2);
    chk("rst_async_busy",   int'(u_if.busy), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    k = cyc + 1;
    exp_at(k, "idle", 0, 2, 0);
    exp_at(k + 2, "idle2", 0, 2, 0);
    wait_until(k + 3);

    // Full fill
    k = cyc + 1;
    exp_at(k,      "fill_start", 0, 1, 1);
    exp_at(k + 3,  "fill_pre1",  0, 1, 1);
    exp_at(k + 4,  "fill_l1",    1, 1, 1);
    exp_at(k + 8,  "fill_l2",    2, 1, 1);
    exp_at(k + 11, "fill_pre3",  2, 1, 1);
    exp_at(k + 12, "fill_done",  3, 3, 0);
    pulse(1'b1, 1'b0);
    wait_until(k + 13);

    // Requests ignored at level MAX
    k = cyc + 1;
    exp_at(k,     "fill_at_max",  3, 3, 0);
    exp_at(k + 4, "fill_at_max4", 3, 3, 0);
    pulse(1'b1, 1'b0);
    wait_until(k + 5);
    k = cyc + 1;
    exp_at(k,     "both_req",  3, 3, 0);
    exp_at(k + 4, "both_req4", 3, 3, 0);
    pulse(1'b1, 1'b1);
    wait_until(k + 5);

    // Full drain
    k = cyc + 1;
    exp_at(k,      "drain_start", 3, 1, 1);
    exp_at(k + 4,  "drain_l2",    2, 1, 1);
    exp_at(k + 8,  "drain_l1",    1, 1, 1);
    exp_at(k + 11, "drain_pre0",  1, 1, 1);
    exp_at(k + 12, "drain_done",  0, 2, 0);
    pulse(1'b0, 1'b1);
    wait_until(k + 13);

    // Gate not ok, and drain at level 0: both ignored
    u_if.gate_state = 2'b10;
    k = cyc + 1;
    exp_at(k,     "fill_gate_open",  0, 2, 0);
    exp_at(k + 4, "fill_gate_open4", 0, 2, 0);
    pulse(1'b1, 1'b0);
    wait_until(k + 5);
    u_if.gate_state = 2'b00;
    k = cyc + 1;
    exp_at(k + 4, "drain_at_zero", 0, 2, 0);
    pulse(1'b0, 1'b1);
    wait_until(k + 5);

    // Fill with hold: gate open for edges k+3..k+7
    k = cyc + 1;
    exp_at(k + 2,  "hold_pre",  0, 1, 1);
    exp_at(k + 5,  "hold_mid",  0, 1, 1);
    exp_at(k + 7,  "hold_end",  0, 1, 1);
    exp_at(k + 8,  "hold_res",  0, 1, 1);
    exp_at(k + 9,  "hold_l1",   1, 1, 1);
    exp_at(k + 13, "hold_l2",   2, 1, 1);
    exp_at(k + 16, "hold_pre3", 2, 1, 1);
    exp_at(k + 17, "hold_done", 3, 3, 0);
    pulse(1'b1, 1'b0);
    wait_until(k + 2);
    u_if.gate_state = 2'b01;
    wait_until(k + 7);
    u_if.gate_state = 2'b00;
    wait_until(k + 18);

    // Return to 0 without checks
    pulse(1'b0, 1'b1);
    wait_until(cyc + 14);
    chk("back_to_zero", int'(u_if.level), 0);

    // Drain requested during fill: fill completes
    k = cyc + 1;
    exp_at(k + 6,  "rev_mid",  1, 1, 1);
    exp_at(k + 10, "rev_mid2", 2, 1, 1);
    exp_at(k + 12, "rev_done", 3, 3, 0);
    pulse(1'b1, 1'b0);
    wait_until(k + 4);
    u_if.drain_req = 1'b1;
    wait_until(k + 7);
    u_if.drain_req = 1'b0;
    wait_until(k + 13);

    // Back to 0, then reset mid-fill at level 2
    pulse(1'b0, 1'b1);
    wait_until(cyc + 14);
    k = cyc + 1;
    exp_at(k + 8, "mid_l2", 2, 1, 1);
    pulse(1'b1, 1'b0);
    wait_until(k + 9);
    reset = 1'b1;
    #1;
    chk("rst_mid_level",  int'(u_if.level), 0);
    chk("rst_mid_status", int'(u_if.water_status), 2);
    chk("rst_mid_busy",   int'(u_if.busy), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    k = cyc + 1;
    exp_at(k + 5, "post_rst", 0, 2, 0);
    wait_until(k + 6);

    chk("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_water_level.md
Name: lock_water_level

Overview:
- Models and controls the lock-chamber water level for the canal lock.
- Accepts fill and drain requests from the operator panel and steps a level counter at a fixed rate.
- Publishes the 2-bit water_status code consumed directly by the downstream gate controller.
- Sits immediately upstream of the gate controller and also reads its gate_state, so valves never run while a gate is open.

Parameters:
- LEVEL_MAX, 15, level count at the upper-river water height; level 0 is the lower-river height.
- LW, 4, width of the level counter; must satisfy 2^LW > LEVEL_MAX.
- STEP_DIV, 50, clock cycles per one-unit level change; must be >= 2.
- DW, 6, prescaler width; must satisfy 2^DW >= STEP_DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- fill_req  input  1  request to raise the chamber to upper height; level-sensitive, sampled on the clock edge.
- drain_req  input  1  request to lower the chamber to lower height; level-sensitive, sampled on the clock edge.
- gate_state  input  2  from gate controller: 2'b00 both gates closed, 2'b01 upper gate open, 2'b10 lower gate open.
- water_status  output  2  2'b10 at low (level 0, idle); 2'b11 at high (level LEVEL_MAX, idle); 2'b01 moving or held; 2'b00 idle at an intermediate level (unreachable in normal operation).
- level  output  LW  current chamber level, 0..LEVEL_MAX.
- busy  output  1  high while in FILLING or DRAINING.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, level=0, prescaler=0.
  - Resulting outputs: water_status=2'b10, busy=0.
  - Reset asserted mid-fill or mid-drain aborts immediately to these values.
- States: IDLE, FILLING, DRAINING.
- Outputs are a combinational decode of registered state and level only; there is no combinational path from any input.
- gate_ok = (gate_state == 2'b00).
- IDLE transitions:
  - fill_req & ~drain_req & gate_ok & level<LEVEL_MAX -> FILLING, prescaler cleared.
  - drain_req & ~fill_req & gate_ok & level>0 -> DRAINING, prescaler cleared.
  - fill_req & drain_req together: ignored, stay IDLE.
  - Request with gate not ok: ignored, stay IDLE.
  - fill_req at LEVEL_MAX or drain_req at 0: ignored, stay IDLE.
- FILLING / DRAINING, gate_ok:
  - Prescaler increments each cycle.
  - At prescaler==STEP_DIV-1: prescaler wraps to 0 and level steps +1 (FILLING) or -1 (DRAINING).
  - The step that makes level reach LEVEL_MAX (fill) or 0 (drain) also returns the FSM to IDLE on the same edge.
- FILLING / DRAINING, gate not ok (hold):
  - Prescaler and level frozen; state unchanged; busy stays 1; water_status stays 2'b01.
  - Resumes from the frozen prescaler value when gate_state returns to 2'b00.
- All requests, including the opposite direction, are ignored while busy; there is no reversal mid-move.
- Latency:
  - Request sampled at edge k -> busy=1 and water_status=2'b01 after edge k.
  - First level step at edge k+STEP_DIV.
  - Full 0->LEVEL_MAX traverse takes LEVEL_MAX*STEP_DIV cycles (no holds).
- Level arithmetic is unsigned and saturating by construction: never exceeds LEVEL_MAX, never goes below 0, no wrap-around.
- water_status=2'b11 only when IDLE & level==LEVEL_MAX; water_status=2'b10 only when IDLE & level==0.

Test Plan (LEVEL_MAX=3, STEP_DIV=4):
- Reset then idle: after reset release -> level=0, water_status=2'b10, busy=0; async reset assertion between edges clears outputs without waiting for a clock edge.
- Full fill: gate_state=00, fill_req 1 cycle at edge k -> busy=1 and status=01 after k; level=1,2,3 at k+4, k+8, k+12; at k+12 status=2'b11, busy=0.
- Full drain from 3: drain_req 1 cycle -> level 2,1,0 at +4, +8, +12; then status=2'b10, busy=0.
- Hold: fill starting at 0, gate_state=01 for 5 cycles beginning 2 cycles into a step -> level frozen during hold; final level=3 reached 5 cycles later than the no-hold case (k+17).
- Ignored requests:
  - fill_req & drain_req together -> stays IDLE, level unchanged.
  - fill_req while gate_state=10 -> stays IDLE.
  - fill_req at level 3 -> stays IDLE, status=11.
  - drain_req during FILLING -> fill completes normally.
- Reset mid-operation: assert reset with level=2 while FILLING -> level=0, IDLE, status=2'b10 immediately.
